btb_gshare_predictor: RTL and testbench
=======================================

// Module: btb_gshare_predictor
// PURPOSE
//  Parametrised next-PC predictor for the IF stage: a tagged branch target buffer plus a table of 2-bit saturating counters.
//  Counter indexing is either bimodal (PC) or gshare (PC XOR global history).
//  Prediction is combinational on the fetch PC. Training comes from the branch-resolve stage through a single update port.
//  After reset, a sweep FSM clears the tables in hardware; no simulation-only initial blocks are used.
// PARAMETERS
//  WORD_SIZE   16     PC / target width
//  INDEX_BITS  8      log2 table depth (2**INDEX_BITS entries), 2..10
//  TAG_BITS    8      tag width; PC[INDEX_BITS+TAG_BITS-1:INDEX_BITS]; INDEX_BITS+TAG_BITS <= WORD_SIZE
//  HIST_BITS   0      0 = bimodal; 1..INDEX_BITS = gshare history length
//  CTR_INIT    2'b01  counter value written by the reset sweep (weakly not-taken)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  reset_n        in   1           synchronous, active-low reset
//  ready          out  1           0 while sweeping; predictions and updates are valid only when 1
//  pred_pc        in   WORD_SIZE   fetch PC
//  pred_next_pc   out  WORD_SIZE   predicted next PC
//  pred_taken     out  1           BTB hit && counter[1]
//  pred_hit       out  1           valid entry with matching tag
//  pred_hist      out  max(1,HIST_BITS) GHR snapshot; pipeline carries it to resolve
//  upd_valid      in   1           one resolved conditional branch this cycle
//  upd_pc         in   WORD_SIZE   PC of the resolved branch
//  upd_hist       in   max(1,HIST_BITS) pred_hist captured when that branch was fetched
//  upd_taken      in   1           actual outcome
//  upd_target     in   WORD_SIZE   computed taken target (PC+Imm)
// BEHAVIOUR
//  State per entry: valid, tag, target (BTB, indexed by PC[INDEX_BITS-1:0]) and ctr[1:0] (counter table).
//  Counter index: cidx = PC idx XOR {zero-ext hist}. With HIST_BITS=0, cidx = PC idx.
//  FSM states:
//   - SWEEP: each cycle clear valid[ptr] and set ctr[ptr]=CTR_INIT, ptr++.
//     After ptr = 2**INDEX_BITS-1 is cleared, go to RUN next cycle.
//   - RUN: normal operation.
//   - reset_n=0 at any edge, including mid-sweep or mid-run: state=SWEEP, ptr=0, GHR=0.
//  Reset values: ready=0, GHR=0. During SWEEP: pred_hit=0, pred_taken=0, pred_next_pc=pred_pc+1.
//  Sweep length is exactly 2**INDEX_BITS cycles after reset_n rises.
//  ready is registered: ready=1 iff state==RUN.
//  Predict: pred_next_pc = pred_taken ? target : pred_pc+1, mod 2**WORD_SIZE (0xFFFF -> 0x0000). Zero latency.
//  Update (upd_valid && ready), written at the next edge:
//   - BTB hit: ctr saturates (3+taken=3, 0-not taken=0); if taken, target<=upd_target.
//   - BTB miss && taken: allocate valid=1, tag, target; ctr[cidx]<=2'b10.
//   - BTB miss && not taken: no table change.
//   - GHR <= {GHR[HIST_BITS-2:0], upd_taken} on every accepted update.
//  upd_valid is ignored during SWEEP (no table or GHR change).
//  Same-cycle predict and update to the same index: the prediction uses pre-update state (no bypass).
// STRUCTURE
//  Shared package: CTR_SNT/CTR_WNT/CTR_WT/CTR_ST encodings and FSM state encoding (ST_SWEEP, ST_RUN).
//  One sub-module: sat_counter2 (combinational next-value of a 2-bit saturating counter given taken).
//  Tables are flop arrays; no memory macros.
// TESTING
//  Release reset with INDEX_BITS=8 -> ready=0 for exactly 256 cycles then 1; pred_next_pc=pc+1 throughout.
//  Update pc=0x0010, taken, target=0x0030 -> next cycle pred(0x0010): hit=1, taken=1, next_pc=0x0030.
//  Two not-taken updates of pc=0x0010 -> ctr 10->01->00; pred_taken=0, next_pc=0x0011, hit=1.
//  Alias pc=0x0110 taken after 0x0010 entry -> tag replaced; pred(0x0010) hit=0. pred_pc=0xFFFF -> next_pc=0x0000.
//  HIST_BITS=2, alternating T/NT on one branch with upd_hist fed back -> predictions match after warm-up.
//  Assert reset_n mid-run and mid-sweep -> ready=0, all hits cleared, full sweep restarts at ptr=0.

Source files
------------

// File: rtl/btb_gshare_predictor_pkg.sv
// Shared encodings for the BTB/gshare next-PC predictor: counter states and FSM states.
package btb_gshare_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [0:0] ST_SWEEP = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/btb_gshare_predictor_sat_counter2.sv
// Next value of a 2-bit saturating branch counter given the resolved outcome.
module sat_counter2
    import btb_gshare_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_gshare_predictor.sv
// Next-PC predictor: tagged BTB plus 2-bit counter table, bimodal or gshare indexed.
// Tables are cleared by a hardware sweep after reset; ready marks the end of the sweep.
module btb_gshare_predictor
    import btb_gshare_predictor_pkg::*;
#(
    parameter int         WORD_SIZE  = 16,
    parameter int         INDEX_BITS = 8,
    parameter int         TAG_BITS   = 8,
    parameter int         HIST_BITS  = 0,
    parameter logic [1:0] CTR_INIT   = 2'b01,
    localparam int        HW         = (HIST_BITS == 0) ? 1 : HIST_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 ready,
    input  logic [WORD_SIZE-1:0] pred_pc,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    output logic                 pred_taken,
    output logic                 pred_hit,
    output logic [HW-1:0]        pred_hist,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [HW-1:0]        upd_hist,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [0:0]            state;
    logic [INDEX_BITS-1:0] ptr;
    logic [HW-1:0]         ghr;

    logic [DEPTH-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_q    [DEPTH];
    logic [WORD_SIZE-1:0]  target_q [DEPTH];
    logic [1:0]            ctr_q    [DEPTH];

    logic [INDEX_BITS-1:0] p_idx, p_cidx, u_idx, u_cidx;
    logic [TAG_BITS-1:0]   p_tag, u_tag;
    logic                  u_hit, upd_en;
    logic [1:0]            u_ctr_next;

    // Bimodal builds ignore history entirely so the counter index is just the PC index.
    function automatic logic [INDEX_BITS-1:0] hist_ext(input logic [HW-1:0] h);
        return (HIST_BITS == 0) ? '0 : INDEX_BITS'(h);
    endfunction

    assign ready     = (state == ST_RUN);
    assign pred_hist = ghr;

    assign p_idx  = pred_pc[INDEX_BITS-1:0];
    assign p_tag  = pred_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    assign p_cidx = p_idx ^ hist_ext(ghr);

    assign pred_hit     = ready && valid[p_idx] && (tag_q[p_idx] == p_tag);
    assign pred_taken   = pred_hit && ctr_q[p_cidx][1];
    assign pred_next_pc = pred_taken ? target_q[p_idx] : pred_pc + WORD_SIZE'(1);

    assign u_idx  = upd_pc[INDEX_BITS-1:0];
    assign u_tag  = upd_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    assign u_cidx = u_idx ^ hist_ext(upd_hist);
    assign u_hit  = valid[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_en = reset_n && ready && upd_valid;

    sat_counter2 u_sat (
        .ctr      (ctr_q[u_cidx]),
        .taken    (upd_taken),
        .ctr_next (u_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_SWEEP;
            ptr   <= '0;
            ghr   <= '0;
        end else if (state == ST_SWEEP) begin
            ptr <= ptr + INDEX_BITS'(1);
            if (ptr == '1) state <= ST_RUN;
        end else if (upd_valid) begin
            ghr <= (HIST_BITS == 0) ? '0 : HW'({ghr, upd_taken});
        end
    end

    // Table storage has no reset of its own; the sweep walks every entry instead.
    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) begin
            valid[ptr] <= 1'b0;
            ctr_q[ptr] <= CTR_INIT;
        end else if (upd_en) begin
            if (u_hit) begin
                ctr_q[u_cidx] <= u_ctr_next;
                if (upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid[u_idx]    <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_cidx]   <= CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Directed bench: a bimodal instance driven from a vector table and a gshare instance
// driven with a fed-back alternating branch; both share clock and reset.
module tb_btb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        b_ready, b_pred_taken, b_pred_hit, b_upd_valid, b_upd_taken;
    logic [15:0] b_pred_pc, b_pred_next_pc, b_upd_pc, b_upd_target;
    logic [0:0]  b_pred_hist, b_upd_hist;

    logic        g_ready, g_pred_taken, g_pred_hit, g_upd_valid, g_upd_taken;
    logic [15:0] g_pred_pc, g_pred_next_pc, g_upd_pc, g_upd_target;
    logic [1:0]  g_pred_hist, g_upd_hist;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    btb_gshare_predictor dut (
        .clk(clk), .reset_n(reset_n), .ready(b_ready),
        .pred_pc(b_pred_pc), .pred_next_pc(b_pred_next_pc), .pred_taken(b_pred_taken),
        .pred_hit(b_pred_hit), .pred_hist(b_pred_hist),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_hist(b_upd_hist),
        .upd_taken(b_upd_taken), .upd_target(b_upd_target)
    );

    btb_gshare_predictor #(.HIST_BITS(2)) dut_g (
        .clk(clk), .reset_n(reset_n), .ready(g_ready),
        .pred_pc(g_pred_pc), .pred_next_pc(g_pred_next_pc), .pred_taken(g_pred_taken),
        .pred_hit(g_pred_hit), .pred_hist(g_pred_hist),
        .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_hist(g_upd_hist),
        .upd_taken(g_upd_taken), .upd_target(g_upd_target)
    );

    typedef struct {
        logic        do_upd;
        logic [15:0] upd_pc;
        logic        upd_taken;
        logic [15:0] upd_target;
        logic [15:0] pc;
        logic        exp_hit;
        logic        exp_taken;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after an edge with reset_n already released; abort_at>0 re-asserts reset mid-sweep.
    task automatic run_sweep(input int abort_at);
        logic [15:0] pc;
        for (int k = 1; k <= 256; k++) begin
            pc = 16'(k * 259);
            b_pred_pc = pc;
            if (k == 10) begin
                b_upd_valid = 1'b1; b_upd_pc = 16'h0040; b_upd_taken = 1'b1; b_upd_target = 16'h0099;
                g_upd_valid = 1'b1; g_upd_pc = 16'h0040; g_upd_taken = 1'b1; g_upd_target = 16'h0099;
                g_upd_hist = 2'b00;
            end
            @(posedge clk); #1;
            b_upd_valid = 1'b0;
            g_upd_valid = 1'b0;
            if (k == abort_at) begin
                reset_n = 1'b0;
                @(posedge clk); #1;
                chk("abort_ready", {31'b0, b_ready}, 32'd0);
                chk("abort_g_ready", {31'b0, g_ready}, 32'd0);
                reset_n = 1'b1;
                return;
            end
            @(negedge clk);
            chk("sweep_ready", {31'b0, b_ready}, {31'b0, (k == 256)});
            chk("sweep_g_ready", {31'b0, g_ready}, {31'b0, (k == 256)});
            if (k < 256) begin
                chk("sweep_hit", {31'b0, b_pred_hit}, 32'd0);
                chk("sweep_next", {16'b0, b_pred_next_pc}, {16'b0, pc + 16'd1});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] h;
        logic       exp_t;

        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0011};
        vecs[1]  = '{1'b1, 16'h0010, 1'b1, 16'h0030, 16'h0010, 1'b1, 1'b1, 16'h0030};
        vecs[2]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b0, 16'h0011};
        vecs[3]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b0, 16'h0011};
        vecs[4]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b0, 16'h0011};
        vecs[5]  = '{1'b1, 16'h0010, 1'b1, 16'h0030, 16'h0010, 1'b1, 1'b0, 16'h0011};
        vecs[6]  = '{1'b1, 16'h0010, 1'b1, 16'h0030, 16'h0010, 1'b1, 1'b1, 16'h0030};
        vecs[7]  = '{1'b1, 16'h0010, 1'b1, 16'h0031, 16'h0010, 1'b1, 1'b1, 16'h0031};
        vecs[8]  = '{1'b1, 16'h0010, 1'b1, 16'h0031, 16'h0010, 1'b1, 1'b1, 16'h0031};
        vecs[9]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b1, 16'h0031};
        vecs[10] = '{1'b1, 16'h0110, 1'b1, 16'h0200, 16'h0010, 1'b0, 1'b0, 16'h0011};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0110, 1'b1, 1'b1, 16'h0200};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
        vecs[13] = '{1'b1, 16'h1234, 1'b0, 16'h5555, 16'h1234, 1'b0, 1'b0, 16'h1235};
        vecs[14] = '{1'b1, 16'h0210, 1'b0, 16'h4444, 16'h0110, 1'b1, 1'b1, 16'h0200};

        reset_n = 1'b0;
        b_pred_pc = '0; b_upd_valid = 1'b0; b_upd_pc = '0; b_upd_hist = '0; b_upd_taken = 1'b0; b_upd_target = '0;
        g_pred_pc = '0; g_upd_valid = 1'b0; g_upd_pc = '0; g_upd_hist = '0; g_upd_taken = 1'b0; g_upd_target = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, b_ready}, 32'd0);
        chk("reset_g_hist", {30'b0, g_pred_hist}, 32'd0);
        reset_n = 1'b1;
        run_sweep(0);

        b_pred_pc = 16'h0040;
        g_pred_pc = 16'h0040;
        #1;
        chk("sweep_upd_ignored", {31'b0, b_pred_hit}, 32'd0);
        chk("sweep_upd_g_hit", {31'b0, g_pred_hit}, 32'd0);
        chk("sweep_upd_g_hist", {30'b0, g_pred_hist}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_upd) begin
                b_upd_valid = 1'b1; b_upd_pc = vecs[i].upd_pc;
                b_upd_taken = vecs[i].upd_taken; b_upd_target = vecs[i].upd_target;
                @(posedge clk); #1;
                b_upd_valid = 1'b0;
            end
            b_pred_pc = vecs[i].pc;
            @(negedge clk);
            chk($sformatf("vec%0d_hit", i), {31'b0, b_pred_hit}, {31'b0, vecs[i].exp_hit});
            chk($sformatf("vec%0d_taken", i), {31'b0, b_pred_taken}, {31'b0, vecs[i].exp_taken});
            chk($sformatf("vec%0d_next", i), {16'b0, b_pred_next_pc}, {16'b0, vecs[i].exp_next});
        end

        // Predict and update the same new entry in one cycle: prediction sees the old state.
        b_pred_pc = 16'h0020;
        b_upd_valid = 1'b1; b_upd_pc = 16'h0020; b_upd_taken = 1'b1; b_upd_target = 16'h0077;
        #1;
        chk("same_cycle_hit", {31'b0, b_pred_hit}, 32'd0);
        chk("same_cycle_next", {16'b0, b_pred_next_pc}, 32'h0021);
        @(posedge clk); #1;
        b_upd_valid = 1'b0;
        chk("after_update_hit", {31'b0, b_pred_hit}, 32'd1);
        chk("after_update_next", {16'b0, b_pred_next_pc}, 32'h0077);
        @(negedge clk);

        // Alternating T/NT branch at 0x0040 on the gshare instance, history fed back.
        for (int i = 0; i < 10; i++) begin
            g_pred_pc = 16'h0040;
            #1;
            exp_t = (i >= 4) && (i % 2 == 0);
            chk($sformatf("gs%0d_hist", i), {30'b0, g_pred_hist},
                (i == 0) ? 32'd0 : ((i % 2 == 1) ? 32'd1 : 32'd2));
            chk($sformatf("gs%0d_hit", i), {31'b0, g_pred_hit}, {31'b0, (i >= 1)});
            chk($sformatf("gs%0d_taken", i), {31'b0, g_pred_taken}, {31'b0, exp_t});
            chk($sformatf("gs%0d_next", i), {16'b0, g_pred_next_pc}, exp_t ? 32'h0080 : 32'h0041);
            h = g_pred_hist;
            g_upd_valid = 1'b1; g_upd_pc = 16'h0040; g_upd_hist = h;
            g_upd_taken = (i % 2 == 0); g_upd_target = 16'h0080;
            @(posedge clk); #1;
            g_upd_valid = 1'b0;
            @(negedge clk);
        end

        // Reset mid-run, then reset again mid-sweep; the final sweep must take the full length.
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        b_pred_pc = 16'h0110;
        g_pred_pc = 16'h0040;
        #1;
        chk("runrst_ready", {31'b0, b_ready}, 32'd0);
        chk("runrst_hit", {31'b0, b_pred_hit}, 32'd0);
        chk("runrst_g_hit", {31'b0, g_pred_hit}, 32'd0);
        chk("runrst_g_hist", {30'b0, g_pred_hist}, 32'd0);
        reset_n = 1'b1;
        run_sweep(100);
        run_sweep(0);

        b_pred_pc = 16'h0110;
        g_pred_pc = 16'h0040;
        #1;
        chk("cleared_hit", {31'b0, b_pred_hit}, 32'd0);
        chk("cleared_next", {16'b0, b_pred_next_pc}, 32'h0111);
        chk("cleared_g_hit", {31'b0, g_pred_hit}, 32'd0);
        b_pred_pc = 16'h0010;
        #1;
        chk("cleared_hit_0010", {31'b0, b_pred_hit}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
